// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: pulls bytes from the RX FIFO over APB, finds the
// 802.15.4 preamble/SFD/PHR and streams the PSDU out with sof/eof markers.
module rx_frame_ctrl #(
    parameter int         PRE_BYTES = 4,
    parameter logic [7:0] SFD       = 8'hA7,
    parameter int         MAX_PSDU  = 127,
    parameter int         TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    output logic       f_psel,
    output logic       f_penable,
    output logic       f_pwrite,
    input  logic       f_pready,
    input  logic       f_pslverr,
    input  logic [7:0] f_prdata,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_sof,
    output logic       m_eof,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [6:0] frame_len,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(PRE_BYTES + 1);

    typedef enum logic [1:0] {RD_IDLE, RD_SETUP, RD_ACCESS, RD_CAPT} rd_state_t;
    typedef enum logic [1:0] {HUNT_PRE, HUNT_SFD, PHR, PAYLOAD} ps_state_t;

    rd_state_t rd_state;
    ps_state_t ps_state;
    logic [TW-1:0] tmo_cnt;
    logic [PW-1:0] pre_cnt;
    logic [6:0]    remaining;

    logic launch;
    logic rd_empty;
    logic byte_stb;
    logic timeout_hit;
    logic eof_done;
    logic [6:0] phr_len;

    assign f_pwrite    = 1'b0;
    assign busy        = (ps_state != HUNT_PRE);
    assign launch      = enable && (!m_valid || m_ready);
    assign rd_empty    = (rd_state == RD_ACCESS) && f_pready && f_pslverr;
    assign byte_stb    = (rd_state == RD_CAPT) && enable;
    assign timeout_hit = busy && (tmo_cnt >= TW'(TIMEOUT));
    assign eof_done    = m_valid && m_ready && m_eof;
    assign phr_len     = f_prdata[6:0];

    // APB read sequencer; a started access always runs to f_pready
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state  <= RD_IDLE;
            f_psel    <= 1'b0;
            f_penable <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (launch) begin
                        rd_state <= RD_SETUP;
                        f_psel   <= 1'b1;
                    end
                end
                RD_SETUP: begin
                    rd_state  <= RD_ACCESS;
                    f_penable <= 1'b1;
                end
                RD_ACCESS: begin
                    if (f_pready) begin
                        f_psel    <= 1'b0;
                        f_penable <= 1'b0;
                        rd_state  <= f_pslverr ? RD_IDLE : RD_CAPT;
                    end
                end
                default: begin
                    if (launch && ps_state != PAYLOAD) begin
                        rd_state <= RD_SETUP;
                        f_psel   <= 1'b1;
                    end else begin
                        rd_state <= RD_IDLE;
                    end
                end
            endcase
        end
    end

    // Mid-frame starvation counter, cleared by every delivered byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (byte_stb || !busy) begin
            tmo_cnt <= '0;
        end else if (rd_empty && tmo_cnt < TW'(TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Frame parser with PSDU output stream and status pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps_state   <= HUNT_PRE;
            pre_cnt    <= '0;
            remaining  <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_sof      <= 1'b0;
            m_eof      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= '0;
            frame_len  <= '0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
                m_sof   <= 1'b0;
                m_eof   <= 1'b0;
                if (m_eof) begin
                    frame_done <= 1'b1;
                    ps_state   <= HUNT_PRE;
                end
            end
            if (!enable) begin
                if (busy && !eof_done) begin
                    frame_err <= 1'b1;
                    err_code  <= 2'b11;
                    m_valid   <= 1'b0;
                    m_sof     <= 1'b0;
                    m_eof     <= 1'b0;
                end
                ps_state <= HUNT_PRE;
                pre_cnt  <= '0;
            end else if (timeout_hit && !eof_done) begin
                frame_err <= 1'b1;
                err_code  <= 2'b10;
                m_valid   <= 1'b0;
                m_sof     <= 1'b0;
                m_eof     <= 1'b0;
                ps_state  <= HUNT_PRE;
                pre_cnt   <= '0;
            end else if (byte_stb) begin
                case (ps_state)
                    HUNT_PRE: begin
                        if (f_prdata == 8'h00) begin
                            if (pre_cnt >= PW'(PRE_BYTES - 1)) begin
                                ps_state <= HUNT_SFD;
                                pre_cnt  <= '0;
                            end else begin
                                pre_cnt <= pre_cnt + 1'b1;
                            end
                        end else begin
                            pre_cnt <= '0;
                        end
                    end
                    HUNT_SFD: begin
                        if (f_prdata == SFD) begin
                            ps_state <= PHR;
                        end else if (f_prdata != 8'h00) begin
                            ps_state <= HUNT_PRE;
                            pre_cnt  <= '0;
                        end
                    end
                    PHR: begin
                        if (phr_len == 7'd0 || 32'(phr_len) > MAX_PSDU) begin
                            frame_err <= 1'b1;
                            err_code  <= 2'b01;
                            ps_state  <= HUNT_PRE;
                        end else begin
                            frame_len <= phr_len;
                            remaining <= phr_len;
                            ps_state  <= PAYLOAD;
                        end
                    end
                    default: begin
                        m_data    <= f_prdata;
                        m_valid   <= 1'b1;
                        m_sof     <= (remaining == frame_len);
                        m_eof     <= (remaining == 7'd1);
                        remaining <= remaining - 7'd1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: scoreboard bench with an APB FIFO model feeding rx_frame_ctrl.
module tb_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       f_psel, f_penable, f_pwrite;
    logic       f_pready = 1'b0;
    logic       f_pslverr = 1'b0;
    logic [7:0] f_prdata = 8'h00;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       m_sof, m_eof, frame_done, frame_err, busy;
    logic [1:0] err_code;
    logic [6:0] frame_len;

    typedef struct packed {logic [7:0] data; logic sof; logic eof;} beat_t;
    typedef struct packed {logic is_err; logic [1:0] code; logic [6:0] len;} evt_t;

    beat_t      exp_beats[$];
    evt_t       exp_evts[$];
    logic [7:0] fifo[$];
    int         checks = 0;
    int         failures = 0;
    int         wait_states = 0;
    int         ws_cnt = 0;
    logic       in_access = 1'b0;
    logic [7:0] hold = 8'h00;

    rx_frame_ctrl dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .f_psel(f_psel), .f_penable(f_penable), .f_pwrite(f_pwrite),
        .f_pready(f_pready), .f_pslverr(f_pslverr), .f_prdata(f_prdata),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sof(m_sof), .m_eof(m_eof), .frame_done(frame_done),
        .frame_err(frame_err), .err_code(err_code), .frame_len(frame_len),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        fifo.push_back(b);
    endtask

    task automatic pushHeader(input logic [7:0] phr, input int npre);
        for (int i = 0; i < npre; i++) applyStimulus(8'h00);
        applyStimulus(8'hA7);
        applyStimulus(phr);
    endtask

    task automatic expectBeat(input logic [7:0] d, input logic s, input logic e);
        exp_beats.push_back('{data: d, sof: s, eof: e});
    endtask

    task automatic expectEvent(input logic is_err, input logic [1:0] code, input logic [6:0] len);
        exp_evts.push_back('{is_err: is_err, code: code, len: len});
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((exp_beats.size() != 0 || exp_evts.size() != 0 || fifo.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout: beats=%0d events=%0d fifo=%0d left, required 0",
                     exp_beats.size(), exp_evts.size(), fifo.size());
            exp_beats.delete();
            exp_evts.delete();
            fifo.delete();
        end
        repeat (10) @(negedge clk);
    endtask

    // FIFO completer model: optional wait states, pslverr when empty, data one cycle after completion
    always @(negedge clk) begin
        if (!reset_n) begin
            f_pready  = 1'b0;
            f_pslverr = 1'b0;
            ws_cnt    = 0;
            in_access = 1'b0;
        end else begin
            if (in_access && !(f_psel && f_penable)) begin
                checkOutput("apb_hold", {30'd0, f_psel, f_penable}, 32'd3);
                in_access = 1'b0;
            end
            if (f_psel && f_penable && !f_pready) begin
                in_access = 1'b1;
                if (ws_cnt < wait_states) begin
                    ws_cnt++;
                end else begin
                    checkOutput("apb_hold", {30'd0, f_psel, f_penable}, 32'd3);
                    checkOutput("pwrite", {31'd0, f_pwrite}, 32'd0);
                    checkOutput("read_while_pending", {31'd0, m_valid}, 32'd0);
                    f_pready  = 1'b1;
                    in_access = 1'b0;
                    ws_cnt    = 0;
                    if (fifo.size() == 0) begin
                        f_pslverr = 1'b1;
                    end else begin
                        f_pslverr = 1'b0;
                        hold = fifo.pop_front();
                    end
                end
            end else begin
                if (f_pready && !f_pslverr) f_prdata = hold;
                f_pready  = 1'b0;
                f_pslverr = 1'b0;
            end
        end
    end

    // Byte scoreboard: compare each completed handshake against the next expected beat
    always @(negedge clk) begin
        beat_t e;
        if (reset_n && m_valid && m_ready) begin
            if (exp_beats.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_byte: got %0h sof=%0b eof=%0b, required none", m_data, m_sof, m_eof);
            end else begin
                e = exp_beats.pop_front();
                checkOutput("m_data", {24'd0, m_data}, {24'd0, e.data});
                checkOutput("m_sof", {31'd0, m_sof}, {31'd0, e.sof});
                checkOutput("m_eof", {31'd0, m_eof}, {31'd0, e.eof});
            end
        end
    end

    // Status scoreboard: frame_done / frame_err pulses against expected events
    always @(negedge clk) begin
        evt_t e;
        if (reset_n && (frame_done || frame_err)) begin
            if (exp_evts.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_event: done=%0b err=%0b code=%0d, required none", frame_done, frame_err, err_code);
            end else begin
                e = exp_evts.pop_front();
                checkOutput("evt_kind", {30'd0, frame_err, frame_done}, e.is_err ? 32'd2 : 32'd1);
                if (e.is_err) checkOutput("err_code", {30'd0, err_code}, {30'd0, e.code});
                checkOutput("frame_len", {25'd0, frame_len}, {25'd0, e.len});
            end
        end
    end

    // Global watchdog so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence
    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_psel", {31'd0, f_psel}, 32'd0);
        checkOutput("rst_penable", {31'd0, f_penable}, 32'd0);
        checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("rst_flags", {28'd0, frame_done, frame_err, busy, m_sof}, 32'd0);
        checkOutput("rst_err_code", {30'd0, err_code}, 32'd0);
        checkOutput("rst_frame_len", {25'd0, frame_len}, 32'd0);
        @(posedge clk) #1;
        reset_n = 1'b1;
        enable  = 1'b1;
        m_ready = 1'b1;

        $display("[TB] basic 3-byte frame");
        pushHeader(8'h03, 4);
        applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
        expectBeat(8'h11, 1, 0); expectBeat(8'h22, 0, 0); expectBeat(8'h33, 0, 1);
        expectEvent(0, 2'b00, 7'd3);
        waitDrain(500);

        $display("[TB] short preamble ignored, single-byte frame");
        pushHeader(8'hA7, 2);
        pushHeader(8'h01, 4);
        applyStimulus(8'h5A);
        expectBeat(8'h5A, 1, 1);
        expectEvent(0, 2'b00, 7'd1);
        waitDrain(500);

        $display("[TB] bad lengths");
        pushHeader(8'h00, 4);
        expectEvent(1, 2'b01, 7'd1);
        waitDrain(500);
        checkOutput("busy_after_len0", {31'd0, busy}, 32'd0);
        pushHeader(8'h80, 4);
        expectEvent(1, 2'b01, 7'd1);
        waitDrain(500);
        checkOutput("busy_after_len80", {31'd0, busy}, 32'd0);

        $display("[TB] timeout mid-payload");
        pushHeader(8'h04, 4);
        applyStimulus(8'hB1); applyStimulus(8'hB2);
        expectBeat(8'hB1, 1, 0); expectBeat(8'hB2, 0, 0);
        expectEvent(1, 2'b10, 7'd4);
        waitDrain(5000);
        checkOutput("busy_after_timeout", {31'd0, busy}, 32'd0);
        pushHeader(8'h01, 4);
        applyStimulus(8'h77);
        expectBeat(8'h77, 1, 1);
        expectEvent(0, 2'b00, 7'd1);
        waitDrain(500);
        checkOutput("err_code_held", {30'd0, err_code}, 32'd2);

        $display("[TB] backpressure on first byte");
        @(posedge clk) #1;
        m_ready = 1'b0;
        pushHeader(8'h02, 4);
        applyStimulus(8'hAB); applyStimulus(8'hCD);
        expectBeat(8'hAB, 1, 0); expectBeat(8'hCD, 0, 1);
        expectEvent(0, 2'b00, 7'd2);
        n = 0;
        while (!m_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stall_valid_seen", {31'd0, m_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("stall_m_valid", {31'd0, m_valid}, 32'd1);
            checkOutput("stall_m_data", {24'd0, m_data}, 32'hAB);
            checkOutput("stall_m_sof", {31'd0, m_sof}, 32'd1);
            checkOutput("stall_no_read", {31'd0, f_psel}, 32'd0);
        end
        @(posedge clk) #1;
        m_ready = 1'b1;
        waitDrain(500);

        $display("[TB] disable mid-access");
        wait_states = 4;
        pushHeader(8'h05, 4);
        applyStimulus(8'hC1); applyStimulus(8'hC2);
        expectBeat(8'hC1, 1, 0);
        expectEvent(1, 2'b11, 7'd5);
        n = 0;
        while (exp_beats.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!(f_psel && f_penable) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("access_in_flight", {30'd0, f_psel, f_penable}, 32'd3);
        @(posedge clk) #1;
        enable = 1'b0;
        waitDrain(500);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("disabled_no_read", {31'd0, f_psel}, 32'd0);
        end
        checkOutput("busy_after_disable", {31'd0, busy}, 32'd0);
        @(posedge clk) #1;
        wait_states = 0;
        enable = 1'b1;
        pushHeader(8'h02, 4);
        applyStimulus(8'hE1); applyStimulus(8'hE2);
        expectBeat(8'hE1, 1, 0); expectBeat(8'hE2, 0, 1);
        expectEvent(0, 2'b00, 7'd2);
        waitDrain(500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
